// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the unified-RAM controller.
// Holds the RV32I load/store funct3 codes, the controller FSM states and the
// requester identifiers used by mem_arbiter and lsu_align.
package mem_ctrl_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational size/alignment decode for one RAM access.
// Ports:
//   funct3, we, addr_lo  - access size code, store flag, byte offset in word
//   wdata                - right-aligned store data
//   rdata                - raw word read from RAM
//   byte_en              - RAM lane enables (0 when the access is illegal)
//   wdata_rep            - store data replicated across the lanes
//   rdata_ext            - shifted and sign/zero-extended load data (0 for stores/errors)
//   err                  - misaligned access or illegal funct3
module lsu_align
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic             we,
  input  logic [1:0]       addr_lo,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic [LANES-1:0] byte_en,
  output logic [31:0]      wdata_rep,
  output logic [31:0]      rdata_ext,
  output logic             err
);

  logic [31:0] shifted;

  // Legality: unsigned loads have no store form; codes 3, 6 and 7 are unused.
  always_comb begin
    err = 1'b0;
    case (funct3)
      F3_LB:   err = 1'b0;
      F3_LH:   err = addr_lo[0];
      F3_LW:   err = |addr_lo;
      F3_LBU:  err = we;
      F3_LHU:  err = we | addr_lo[0];
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    byte_en = '0;
    case (funct3)
      F3_LB, F3_LBU: byte_en = 4'(4'b0001 << addr_lo);
      F3_LH, F3_LHU: byte_en = 4'(4'b0011 << addr_lo);
      F3_LW:         byte_en = 4'b1111;
      default:       byte_en = '0;
    endcase
    if (err) byte_en = '0;
  end

  // Replicating the store data lets the lane enables alone select the target bytes.
  always_comb begin
    wdata_rep = '0;
    case (funct3)
      F3_SB:   wdata_rep = {4{wdata[7:0]}};
      F3_SH:   wdata_rep = {2{wdata[15:0]}};
      F3_SW:   wdata_rep = wdata;
      default: wdata_rep = '0;
    endcase
  end

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    rdata_ext = '0;
    case (funct3)
      F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  rdata_ext = {24'd0, shifted[7:0]};
      F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  rdata_ext = {16'd0, shifted[15:0]};
      F3_LW:   rdata_ext = shifted;
      default: rdata_ext = '0;
    endcase
    if (err || we) rdata_ext = '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port sequencer sharing a byte-enabled RAM between fetch and load/store.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   i_req_* / i_resp_*         - instruction-fetch request and response (word only)
//   d_req_* / d_resp_*         - load/store request and response
//   ram_wen, ram_byte_en,
//   ram_addr, ram_wdata        - RAM control, driven only during the ACCESS cycle
//   ram_rdata                  - combinational RAM read data, captured at end of ACCESS
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter bit          D_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  output logic              i_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [2:0]        d_req_funct3,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_err,
  output logic              ram_wen,
  output logic [LANES-1:0]  ram_byte_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t              state_q;
  port_t               port_q;
  port_t               last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                i_resp_valid_q, d_resp_valid_q;
  logic                i_resp_err_q, d_resp_err_q;
  logic [DATA_W-1:0]   i_resp_data_q, d_resp_data_q;

  logic                grant_i, grant_d, access;
  logic [LANES-1:0]    al_byte_en;
  logic [DATA_W-1:0]   al_wdata, al_rdata;
  logic                al_err;

  // Grant decode: data wins under fixed priority, when alone, or when fetch went last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (d_req_valid && (!i_req_valid || D_PRIO || last_q == PORT_I)) grant_d = 1'b1;
      else if (i_req_valid)                                            grant_i = 1'b1;
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  lsu_align u_align (
    .funct3    (f3_q),
    .we        (we_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (ram_rdata),
    .byte_en   (al_byte_en),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .err       (al_err)
  );

  // RAM pins are quiet outside ACCESS; rst blocks any write in the same cycle.
  assign access      = (state_q == ACCESS);
  assign ram_wen     = access & we_q & ~al_err & ~rst;
  assign ram_byte_en = access ? al_byte_en : '0;
  assign ram_addr    = access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign ram_wdata   = access ? al_wdata : '0;

  // Controller FSM: latch on handshake, access the RAM for one cycle, then respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      port_q         <= PORT_I;
      last_q         <= PORT_I;
      addr_q         <= '0;
      we_q           <= 1'b0;
      f3_q           <= '0;
      wdata_q        <= '0;
      i_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      i_resp_err_q   <= 1'b0;
      d_resp_valid_q <= 1'b0;
      d_resp_data_q  <= '0;
      d_resp_err_q   <= 1'b0;
    end else begin
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q <= ACCESS;
            port_q  <= PORT_D;
            last_q  <= PORT_D;
            addr_q  <= d_req_addr;
            we_q    <= d_req_we;
            f3_q    <= d_req_funct3;
            wdata_q <= d_req_wdata;
          end else if (grant_i) begin
            state_q <= ACCESS;
            port_q  <= PORT_I;
            last_q  <= PORT_I;
            addr_q  <= i_req_addr;
            we_q    <= 1'b0;
            f3_q    <= F3_LW;
            wdata_q <= '0;
          end
        end
        ACCESS: begin
          state_q <= IDLE;
          if (port_q == PORT_D) begin
            d_resp_valid_q <= 1'b1;
            d_resp_data_q  <= al_rdata;
            d_resp_err_q   <= al_err;
          end else begin
            i_resp_valid_q <= 1'b1;
            i_resp_data_q  <= al_rdata;
            i_resp_err_q   <= al_err;
          end
        end
      endcase
    end
  end

  assign i_resp_valid = i_resp_valid_q;
  assign i_resp_data  = i_resp_data_q;
  assign i_resp_err   = i_resp_err_q;
  assign d_resp_valid = d_resp_valid_q;
  assign d_resp_data  = d_resp_data_q;
  assign d_resp_err   = d_resp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin instance with a byte-level reference
// memory and response scoreboard, plus a fixed-priority instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_err;
  logic [31:0] i_req_addr, i_resp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_err;
  logic [2:0]  d_req_funct3;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic        ram_wen;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  // Fixed-priority instance
  logic        u1_i_ready, u1_i_rv, u1_i_re, u1_d_ready, u1_d_rv, u1_d_re, u1_wen;
  logic [31:0] u1_i_rd, u1_d_rd, u1_ram_addr, u1_ram_wdata, u1_ram_rdata;
  logic [3:0]  u1_be;
  localparam logic [31:0] U1_WORD = 32'hCAFE_F00D;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_funct3(d_req_funct3), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .ram_wen(ram_wen), .ram_byte_en(ram_byte_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .i_req_valid(1'b1), .i_req_ready(u1_i_ready), .i_req_addr(32'h40),
    .i_resp_valid(u1_i_rv), .i_resp_data(u1_i_rd), .i_resp_err(u1_i_re),
    .d_req_valid(1'b1), .d_req_ready(u1_d_ready), .d_req_we(1'b0),
    .d_req_funct3(3'd2), .d_req_addr(32'h80), .d_req_wdata(32'h0),
    .d_resp_valid(u1_d_rv), .d_resp_data(u1_d_rd), .d_resp_err(u1_d_re),
    .ram_wen(u1_wen), .ram_byte_en(u1_be), .ram_addr(u1_ram_addr),
    .ram_wdata(u1_ram_wdata), .ram_rdata(u1_ram_rdata)
  );

  assign u1_ram_rdata = (u1_ram_addr == 32'h80) ? U1_WORD : 32'hBAD0_BAD0;

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 37 + 11);
  endfunction

  // RAM model for u0: 64 words, address wraps on bits [7:2]
  logic [31:0] mem0 [64];
  assign ram_rdata = mem0[ram_addr[7:2]];
  initial begin : ram0
    for (int a = 0; a < 256; a++) mem0[a / 4][8 * (a % 4) +: 8] = pat(a);
    forever begin
      @(posedge clk);
      if (ram_wen)
        for (int k = 0; k < 4; k++)
          if (ram_byte_en[k]) mem0[ram_addr[7:2]][8 * k +: 8] <= ram_wdata[8 * k +: 8];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic is_d; logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] data; logic err; int cyc; } rsp_t;

  rsp_t   i_q[$];
  rsp_t   d_q[$];
  logic [7:0] ref_mem [256];

  // Monitor / scoreboard: reference model of arbitration, RAM access and responses
  initial begin : mon
    int     cyc, sz;
    req_t   pend;
    logic   pend_v, bsy, last_d, exp_i, exp_d, ill, e_err;
    logic   bsy1, due1, exp1;
    logic [31:0] v, e_data, e_wd;
    logic [3:0]  e_be;
    rsp_t   e;
    for (int a = 0; a < 256; a++) ref_mem[a] = pat(a);
    cyc = 0; pend_v = 0; last_d = 0; bsy1 = 0; due1 = 0;
    forever begin
      @(negedge clk);
      cyc++;

      // responses (u0)
      if (i_resp_valid) begin
        if (i_q.size() == 0) chk("i_resp_unexpected", i_resp_valid, 0);
        else begin
          e = i_q.pop_front();
          chk("i_resp_cycle", cyc, e.cyc);
          chk("i_resp_data", i_resp_data, e.data);
          chk("i_resp_err", i_resp_err, e.err);
        end
      end else if (i_q.size() != 0 && i_q[0].cyc <= cyc) begin
        chk("i_resp_missing", i_resp_valid, 1);
        e = i_q.pop_front();
      end
      if (d_resp_valid) begin
        if (d_q.size() == 0) chk("d_resp_unexpected", d_resp_valid, 0);
        else begin
          e = d_q.pop_front();
          chk("d_resp_cycle", cyc, e.cyc);
          chk("d_resp_data", d_resp_data, e.data);
          chk("d_resp_err", d_resp_err, e.err);
        end
      end else if (d_q.size() != 0 && d_q[0].cyc <= cyc) begin
        chk("d_resp_missing", d_resp_valid, 1);
        e = d_q.pop_front();
      end

      // RAM access cycle (u0)
      bsy = pend_v;
      if (pend_v) begin
        pend_v = 0;
        if (rst) chk("ram_wen_in_reset", ram_wen, 0);
        else begin
          sz  = pend.is_d ? (1 << pend.f3[1:0]) : 4;
          ill = pend.is_d && (pend.f3[1:0] == 2'd3 || (pend.f3[2] && (pend.we || pend.f3[1])));
          e_err = ill || (pend.addr % sz != 0);
          v = 0; e_be = 0;
          if (!e_err) begin
            for (int k = 0; k < sz; k++) begin
              v |= 32'(ref_mem[8'(pend.addr + k)]) << (8 * k);
              e_be[(pend.addr + k) % 4] = 1'b1;
            end
            if (pend.is_d && !pend.f3[2] && sz < 4 && v[8 * sz - 1])
              v |= ~((32'd1 << (8 * sz)) - 1);
          end
          e_data = (e_err || pend.we) ? 32'd0 : v;
          chk("ram_wen", ram_wen, pend.we && !e_err);
          chk("ram_addr", ram_addr, pend.addr & 32'hFFFF_FFFC);
          if (!e_err) chk("ram_byte_en", ram_byte_en, e_be);
          if (pend.we && !e_err) begin
            e_wd = (sz == 1) ? {4{pend.wdata[7:0]}} : (sz == 2) ? {2{pend.wdata[15:0]}} : pend.wdata;
            chk("ram_wdata", ram_wdata, e_wd);
            for (int k = 0; k < sz; k++) ref_mem[8'(pend.addr + k)] = pend.wdata[8 * k +: 8];
          end
          e.data = e_data; e.err = e_err; e.cyc = cyc + 1;
          if (pend.is_d) d_q.push_back(e); else i_q.push_back(e);
        end
      end else begin
        chk("ram_wen_idle", ram_wen, 0);
        chk("ram_byte_en_idle", ram_byte_en, 0);
      end

      // arbitration (u0)
      if (rst) last_d = 0;
      exp_i = 0; exp_d = 0;
      if (!rst && !bsy) begin
        if (i_req_valid && d_req_valid) begin
          exp_d = !last_d; exp_i = last_d;
        end else begin
          exp_i = i_req_valid; exp_d = d_req_valid;
        end
      end
      chk("i_req_ready", i_req_ready, exp_i);
      chk("d_req_ready", d_req_ready, exp_d);
      if (exp_d) begin
        pend.is_d = 1; pend.we = d_req_we; pend.f3 = d_req_funct3;
        pend.addr = d_req_addr; pend.wdata = d_req_wdata; pend_v = 1; last_d = 1;
      end else if (exp_i) begin
        pend.is_d = 0; pend.we = 0; pend.f3 = 3'd2;
        pend.addr = i_req_addr; pend.wdata = 0; pend_v = 1; last_d = 0;
      end

      // fixed-priority instance: data granted on every idle cycle, fetch never
      exp1 = !rst && !bsy1;
      chk("u1_i_req_ready", u1_i_ready, 0);
      chk("u1_d_req_ready", u1_d_ready, exp1);
      chk("u1_i_resp_valid", u1_i_rv, 0);
      chk("u1_d_resp_valid", u1_d_rv, due1);
      if (due1 && u1_d_rv) chk("u1_d_resp_data", u1_d_rd, U1_WORD);
      due1 = bsy1 && !rst;
      bsy1 = exp1;
    end
  end

  task automatic d_issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit wait_rsp,
                         output logic [31:0] rd, output logic re);
    int n;
    @(posedge clk); #1;
    i_req_valid = 0;
    d_req_valid = 1; d_req_we = we; d_req_funct3 = f3; d_req_addr = a; d_req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!d_req_ready && n < 20) begin n++; @(negedge clk); end
    chk("d_handshake", d_req_ready, 1);
    @(posedge clk); #1;
    d_req_valid = 0;
    rd = 0; re = 0;
    if (wait_rsp) begin
      n = 0;
      @(negedge clk);
      while (!d_resp_valid && n < 5) begin n++; @(negedge clk); end
      chk("d_resp_arrived", d_resp_valid, 1);
      rd = d_resp_data; re = d_resp_err;
    end
  endtask

  initial begin : stim
    logic [31:0] rd, pre;
    logic        re;
    // reset with both ports requesting, then continuous contention
    rst = 1;
    i_req_valid = 1; i_req_addr = 32'h40;
    d_req_valid = 1; d_req_we = 0; d_req_funct3 = 3'd2; d_req_addr = 32'h80; d_req_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (16) @(posedge clk);
    #1 i_req_valid = 0; d_req_valid = 0;
    repeat (3) @(posedge clk);

    // byte / halfword stores and sign/zero-extending loads
    d_issue(1, 3'd0, 32'h13, 32'h0000_00A5, 1, rd, re);
    chk("sb_resp_data", rd, 32'h0);
    d_issue(0, 3'd0, 32'h13, 32'h0, 1, rd, re);
    chk("lb_data", rd, 32'hFFFF_FFA5);
    d_issue(0, 3'd4, 32'h13, 32'h0, 1, rd, re);
    chk("lbu_data", rd, 32'h0000_00A5);
    d_issue(1, 3'd1, 32'h22, 32'h0000_8001, 1, rd, re);
    d_issue(0, 3'd1, 32'h22, 32'h0, 1, rd, re);
    chk("lh_data", rd, 32'hFFFF_8001);
    d_issue(0, 3'd2, 32'h21, 32'h0, 1, rd, re);
    chk("lw_misaligned_err", re, 1);
    chk("lw_misaligned_data", rd, 32'h0);

    // reset during the ACCESS cycle of a store drops it
    pre = {pat(8'h33), pat(8'h32), pat(8'h31), pat(8'h30)};
    d_issue(1, 3'd2, 32'h30, 32'hDEAD_BEEF, 0, rd, re);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    d_issue(0, 3'd2, 32'h30, 32'h0, 1, rd, re);
    chk("lw_after_dropped_sw", rd, pre);

    // randomized traffic on both ports
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      i_req_valid  = 1'($urandom_range(0, 1));
      i_req_addr   = $urandom;
      if ($urandom_range(0, 3) != 0) i_req_addr[1:0] = 2'b00;
      d_req_valid  = 1'($urandom_range(0, 1));
      d_req_we     = 1'($urandom_range(0, 1));
      d_req_funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      d_req_addr   = $urandom;
      if ($urandom_range(0, 2) != 0) d_req_addr[1:0] = 2'b00;
      d_req_wdata  = $urandom;
    end
    @(posedge clk); #1 i_req_valid = 0; d_req_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("i_q_drained", i_q.size(), 0);
    chk("d_q_drained", d_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
